// File: rtl/mod_counter_if.sv
// mod_counter_if: control and status bundle for mod_counter.
//   master : drives load/enab/up_dn/sat_mode/cnt_in/max_val/clr_ovf, observes status
//   slave  : the counter; drives cnt_out/tc/ovf/zero
interface mod_counter_if #(
   parameter int unsigned WIDTH = 5
);
   logic             load;
   logic             enab;
   logic             up_dn;
   logic             sat_mode;
   logic [WIDTH-1:0] cnt_in;
   logic [WIDTH-1:0] max_val;
   logic             clr_ovf;
   logic [WIDTH-1:0] cnt_out;
   logic             tc;
   logic             ovf;
   logic             zero;

   modport master (
      output load, enab, up_dn, sat_mode, cnt_in, max_val, clr_ovf,
      input  cnt_out, tc, ovf, zero
   );

   modport slave (
      input  load, enab, up_dn, sat_mode, cnt_in, max_val, clr_ovf,
      output cnt_out, tc, ovf, zero
   );
endinterface

// File: rtl/mod_counter.sv
// mod_counter: up/down modulo counter over 0..max_val with wrap/saturate mode,
// one-cycle terminal-count pulse, sticky overflow flag and optional enable prescaler.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - mod_counter_if.slave (load, enab, up_dn, sat_mode, cnt_in, max_val,
//          clr_ovf in; cnt_out, tc, ovf registered out; zero combinational out)
// Build option: define COUNTER_PRESCALE_EN to step only once per PRESCALE enabled cycles.
module mod_counter #(
   parameter int unsigned WIDTH    = 5,
   parameter int unsigned PRESCALE = 4
) (
   input  logic          clk,
   input  logic          rst,
   mod_counter_if.slave  bus
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             step_c;

`ifdef COUNTER_PRESCALE_EN
   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] pre_q, pre_d;
   logic          pre_term_c;

   // Prescaler counts enabled cycles; the step happens on its terminal value.
   assign pre_term_c = (pre_q == PW'(PRESCALE - 1));
   assign step_c     = bus.enab && pre_term_c;

   always_comb begin
      pre_d = pre_q;
      if (bus.load) begin
         pre_d = '0;
      end else if (bus.enab) begin
         pre_d = pre_term_c ? '0 : pre_q + PW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end
`else
   logic unused_prescale;

   assign unused_prescale = ^32'(PRESCALE);
   assign step_c          = bus.enab;
`endif

   // Next count, terminal pulse and overflow flag.
   always_comb begin
      cnt_d = cnt_q;
      tc_d  = 1'b0;
      ovf_d = ovf_q & ~bus.clr_ovf;
      if (bus.load) begin
         cnt_d = (bus.cnt_in > bus.max_val) ? bus.max_val : bus.cnt_in;
      end else if (step_c) begin
         if (bus.up_dn) begin
            // A count above a lowered max_val is treated as the boundary.
            if (cnt_q < bus.max_val) begin
               cnt_d = cnt_q + WIDTH'(1);
            end else begin
               cnt_d = bus.sat_mode ? bus.max_val : '0;
               tc_d  = 1'b1;
               ovf_d = 1'b1;
            end
         end else begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - WIDTH'(1);
            end else begin
               cnt_d = bus.sat_mode ? '0 : bus.max_val;
               tc_d  = 1'b1;
               ovf_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
         ovf_q <= ovf_d;
      end
   end

   assign bus.cnt_out = cnt_q;
   assign bus.tc      = tc_q;
   assign bus.ovf     = ovf_q;
   assign bus.zero    = (cnt_q == '0);

endmodule
